// File: rtl/led_seq_ctrl.sv
// Start/pause/stop LED pattern sequencer with an internal prescaled step tick.
// Define LED_ACTIVE_LOW_EN to drive led_out inverted (LEDs off = 4'b1111).
module led_seq_ctrl #(
    parameter logic [23:0] CNT_BASE = 24'd12_499_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [1:0] cmd_speed,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] led_out,
    output logic       step_tick,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [23:0] PERIOD0 = CNT_BASE + 24'd1;
    localparam logic        DIR_UP  = 1'b0;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [3:0] LED_POL = 4'b1111;
`else
    localparam logic [3:0] LED_POL = 4'b0000;
`endif

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  speed_q, speed_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  pat_q, pat_d;
    logic        dir_q, dir_d;
    logic        tick_q, tick_d;
    logic [3:0]  led_q;
    logic [23:0] term;
    logic [3:0]  nxt_pat;
    logic        nxt_dir;
    logic        accept;

    function automatic logic [3:0] seed(input logic [1:0] m);
        case (m)
            2'd0:    seed = 4'b0001;
            2'd1:    seed = 4'b1000;
            2'd2:    seed = 4'b0001;
            default: seed = 4'b1111;
        endcase
    endfunction

    assign term      = (PERIOD0 >> speed_q) - 24'd1;
    assign cmd_ready = (state_q == IDLE) || (state_q == PAUSE);
    assign accept    = cmd_valid && cmd_ready;
    assign state     = state_q;
    assign step_tick = tick_q;
    assign led_out   = led_q;

    // Illegal patterns for the current mode fall through to the mode seed.
    always_comb begin
        nxt_pat = seed(mode_q);
        nxt_dir = DIR_UP;
        case (mode_q)
            2'd0: begin
                if (pat_q inside {4'b0001, 4'b0010, 4'b0100})
                    nxt_pat = {pat_q[2:0], 1'b0};
                else if (pat_q == 4'b1000)
                    nxt_pat = 4'b0001;
            end
            2'd1: begin
                if (pat_q inside {4'b1000, 4'b0100, 4'b0010})
                    nxt_pat = {1'b0, pat_q[3:1]};
                else if (pat_q == 4'b0001)
                    nxt_pat = 4'b1000;
            end
            2'd2: begin
                if (pat_q inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
                    if (dir_q == DIR_UP) begin
                        if (pat_q == 4'b1000) begin
                            nxt_pat = 4'b0100;
                            nxt_dir = ~DIR_UP;
                        end else begin
                            nxt_pat = {pat_q[2:0], 1'b0};
                            nxt_dir = nxt_pat[3];
                        end
                    end else begin
                        if (pat_q == 4'b0001) begin
                            nxt_pat = 4'b0010;
                        end else begin
                            nxt_pat = {1'b0, pat_q[3:1]};
                            nxt_dir = ~nxt_pat[0];
                        end
                    end
                end
            end
            default: begin
                nxt_pat = (pat_q == 4'b1111) ? 4'b0000 : 4'b1111;
            end
        endcase
    end

    // A command accepted this cycle is folded in before the start decision.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        if (accept) begin
            mode_d  = cmd_mode;
            speed_d = cmd_speed;
            cnt_d   = '0;
            if (state_q == PAUSE) begin
                pat_d = seed(cmd_mode);
                dir_d = DIR_UP;
            end
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pat_d   = seed(mode_d);
                    dir_d   = DIR_UP;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    pat_d   = '0;
                    cnt_d   = '0;
                    dir_d   = DIR_UP;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (cnt_q == term) begin
                    cnt_d  = '0;
                    pat_d  = nxt_pat;
                    dir_d  = nxt_dir;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    pat_d   = '0;
                    cnt_d   = '0;
                    dir_d   = DIR_UP;
                end else if (!pause && start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pat_d   = '0;
                cnt_d   = '0;
                dir_d   = DIR_UP;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            speed_q <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            dir_q   <= DIR_UP;
            tick_q  <= 1'b0;
            led_q   <= LED_POL;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            led_q   <= pat_d ^ LED_POL;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with CNT_BASE = 15 (16-cycle step at speed 0).
module tb_led_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [1:0] cmd_speed;
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] led_out;
    logic       step_tick;
    logic [1:0] state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    led_seq_ctrl #(.CNT_BASE(24'd15)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode (cmd_mode),
        .cmd_speed(cmd_speed),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .led_out  (led_out),
        .step_tick(step_tick),
        .state    (state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        cv;
        logic [1:0]  md;
        logic [1:0]  sp;
        logic        st;
        logic        pa;
        logic        so;
        int unsigned cyc;
        logic [3:0]  led;
        logic        tick;
        logic [1:0]  st_exp;
        logic        rdy;
    } vec_t;

    vec_t vecs [0:23];

    function automatic vec_t mk(input logic cv, input logic [1:0] md, input logic [1:0] sp,
                                input logic st, input logic pa, input logic so,
                                input int unsigned cyc, input logic [3:0] led,
                                input logic tick, input logic [1:0] s, input logic rdy);
        vec_t v;
        v.cv = cv; v.md = md; v.sp = sp; v.st = st; v.pa = pa; v.so = so;
        v.cyc = cyc; v.led = led; v.tick = tick; v.st_exp = s; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [3:0] led_of(input logic [3:0] p);
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] pat, input logic tick,
                           input logic [1:0] s, input logic rdy);
        chk({tag, ".led"},   {4'h0, led_out},   {4'h0, led_of(pat)});
        chk({tag, ".tick"},  {7'h0, step_tick}, {7'h0, tick});
        chk({tag, ".state"}, {6'h0, state},     {6'h0, s});
        chk({tag, ".ready"}, {7'h0, cmd_ready}, {7'h0, rdy});
    endtask

    // One active edge with the pulses applied, then cyc-1 quiet edges; ends on a negedge.
    task automatic run(input int unsigned cyc);
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        repeat (cyc - 1) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic wait_edges(input int unsigned n);
        repeat (n) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_speed = 2'd0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;

        //            cv md    sp    st pa so cyc led      tk s     rdy
        vecs[0]  = mk(1, 2'd0, 2'd0, 0, 0, 0, 1,  4'b0000, 0, 2'd0, 1);
        vecs[1]  = mk(0, 2'd0, 2'd0, 1, 0, 0, 1,  4'b0001, 0, 2'd1, 0);
        vecs[2]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 15, 4'b0001, 0, 2'd1, 0);
        vecs[3]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 1,  4'b0010, 1, 2'd1, 0);
        vecs[4]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 1,  4'b0010, 0, 2'd1, 0);
        vecs[5]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 15, 4'b0100, 1, 2'd1, 0);
        vecs[6]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 16, 4'b1000, 1, 2'd1, 0);
        vecs[7]  = mk(0, 2'd0, 2'd0, 0, 0, 0, 16, 4'b0001, 1, 2'd1, 0);
        vecs[8]  = mk(0, 2'd0, 2'd0, 0, 0, 1, 1,  4'b0000, 0, 2'd0, 1);
        vecs[9]  = mk(1, 2'd2, 2'd3, 0, 0, 0, 1,  4'b0000, 0, 2'd0, 1);
        vecs[10] = mk(0, 2'd0, 2'd0, 1, 0, 0, 1,  4'b0001, 0, 2'd1, 0);
        vecs[11] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b0010, 1, 2'd1, 0);
        vecs[12] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b0100, 1, 2'd1, 0);
        vecs[13] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b1000, 1, 2'd1, 0);
        vecs[14] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b0100, 1, 2'd1, 0);
        vecs[15] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b0010, 1, 2'd1, 0);
        vecs[16] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b0001, 1, 2'd1, 0);
        vecs[17] = mk(0, 2'd0, 2'd0, 0, 0, 0, 2,  4'b0010, 1, 2'd1, 0);
        vecs[18] = mk(0, 2'd0, 2'd0, 0, 0, 1, 1,  4'b0000, 0, 2'd0, 1);
        vecs[19] = mk(0, 2'd0, 2'd0, 1, 0, 0, 1,  4'b0001, 0, 2'd1, 0);
        vecs[20] = mk(0, 2'd0, 2'd0, 0, 1, 0, 1,  4'b0001, 0, 2'd2, 1);
        vecs[21] = mk(1, 2'd1, 2'd0, 1, 0, 0, 1,  4'b1000, 0, 2'd1, 0);
        vecs[22] = mk(0, 2'd0, 2'd0, 0, 1, 0, 1,  4'b1000, 0, 2'd2, 1);
        vecs[23] = mk(0, 2'd0, 2'd0, 1, 0, 1, 1,  4'b0000, 0, 2'd0, 1);

        // Reset visible before the first clock edge.
        #3;
        chk_all("reset0", 4'b0000, 1'b0, 2'd0, 1'b1);
        wait_edges(2);
        sys_rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            cmd_valid = vecs[i].cv;
            cmd_mode  = vecs[i].md;
            cmd_speed = vecs[i].sp;
            start     = vecs[i].st;
            pause     = vecs[i].pa;
            stop      = vecs[i].so;
            run(vecs[i].cyc);
            cmd_valid = 1'b0;
            chk_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].tick, vecs[i].st_exp, vecs[i].rdy);
        end

        // Pause exactly on the terminal-count cycle, then resume.
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_speed = 2'd0; start = 1'b1;
        run(1);
        cmd_valid = 1'b0;
        chk_all("tc.start", 4'b0001, 1'b0, 2'd1, 1'b0);
        wait_edges(15);
        chk_all("tc.at15", 4'b0001, 1'b0, 2'd1, 1'b0);
        pause = 1'b1;
        run(1);
        chk_all("tc.paused", 4'b0001, 1'b0, 2'd2, 1'b1);
        wait_edges(3);
        chk_all("tc.held", 4'b0001, 1'b0, 2'd2, 1'b1);
        start = 1'b1;
        run(1);
        chk_all("tc.resume", 4'b0001, 1'b0, 2'd1, 1'b0);
        wait_edges(1);
        chk_all("tc.adv", 4'b0010, 1'b1, 2'd1, 1'b0);

        // Command held during RUN is refused until stop returns to IDLE.
        cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_speed = 2'd3;
        #1;
        chk("hs.ready_run", {7'h0, cmd_ready}, 8'h00);
        @(negedge sys_clk);
        wait_edges(15);
        chk_all("hs.mode_kept", 4'b0100, 1'b1, 2'd1, 1'b0);
        stop = 1'b1;
        run(1);
        chk_all("hs.stopped", 4'b0000, 1'b0, 2'd0, 1'b1);
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        start = 1'b1;
        run(1);
        chk_all("hs.newseed", 4'b1000, 1'b0, 2'd1, 1'b0);
        wait_edges(2);
        chk_all("hs.newspeed", 4'b0100, 1'b1, 2'd1, 1'b0);
        stop = 1'b1;
        run(1);

        // Blink mode, then asynchronous reset mid-run.
        cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_speed = 2'd0; start = 1'b1;
        run(1);
        cmd_valid = 1'b0;
        chk_all("blink.seed", 4'b1111, 1'b0, 2'd1, 1'b0);
        wait_edges(16);
        chk_all("blink.off", 4'b0000, 1'b1, 2'd1, 1'b0);
        wait_edges(16);
        chk_all("blink.on", 4'b1111, 1'b1, 2'd1, 1'b0);
        wait_edges(3);
        #1;
        sys_rst = 1'b1;
        #1;
        chk_all("async_rst", 4'b0000, 1'b0, 2'd0, 1'b1);
        wait_edges(2);
        chk_all("rst_hold", 4'b0000, 1'b0, 2'd0, 1'b1);
        sys_rst = 1'b0;
        wait_edges(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
